// File: rtl/axi_rd_4k_splitter_if.sv
// rtl/axi_rd_4k_splitter_if.sv - AXI4 read address/data channel bundle for the 4KiB splitter
//
// Purpose: groups one AXI4 read port (AR + R channels) so the splitter can take
//          its upstream side as a slave modport and its downstream side as a
//          master modport.
// Signals: araddr/arlen/arsize/arburst/arid/arvalid/arready  read address channel
//          rdata/rresp/rid/rlast/rvalid/rready               read data channel
// Modports: master drives AR and rready; slave drives arready and R.
interface axi_rd_4k_splitter_if #(
  parameter int ADDR_WTH = 32,
  parameter int DATA_WTH = 256,
  parameter int ID_WIDTH = 4
);
  logic [ADDR_WTH-1:0] araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_WIDTH-1:0] arid;
  logic                arvalid;
  logic                arready;
  logic [DATA_WTH-1:0] rdata;
  logic [1:0]          rresp;
  logic [ID_WIDTH-1:0] rid;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rid, rlast, rvalid,
    output rready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rid, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_4k_splitter.sv
// rtl/axi_rd_4k_splitter.sv - splits AXI4 INCR read bursts at 2**BOUNDARY_BIT byte boundaries
//
// Purpose: accepts one upstream read burst at a time, issues it downstream as
//          one or more sub-bursts that never cross a 2**BOUNDARY_BIT boundary,
//          and stitches the returned beats back into a single upstream burst.
// Ports:   clk_i      clock
//          rst_i      asynchronous reset, active low
//          s          upstream AXI read port (slave modport)
//          m          downstream AXI read port (master modport)
//          chk_err_o  sticky protocol-check error
// Config:  AXI_RD_SPLIT_CHECK_EN enables the request/rlast protocol checker;
//          when undefined chk_err_o is tied low.
module axi_rd_4k_splitter #(
  parameter int ADDR_WTH     = 32,
  parameter int DATA_WTH     = 256,
  parameter int ID_WIDTH     = 4,
  parameter int BOUNDARY_BIT = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi_rd_4k_splitter_if.slave   s,
  axi_rd_4k_splitter_if.master  m,
  output logic                  chk_err_o
);
  localparam int BYTES   = DATA_WTH / 8;
  localparam int BEAT_SH = $clog2(BYTES);
  // Common width for comparing the 9-bit remaining count with the boundary distance.
  localparam int CW      = (BOUNDARY_BIT + 1 > 9) ? BOUNDARY_BIT + 1 : 9;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DATA} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_WTH-1:0] r_cur_addr;
  logic [8:0]          r_rem;
  logic [8:0]          r_sub_cnt;
  logic [8:0]          r_sub;
  logic [ID_WIDTH-1:0] r_id;
  logic [2:0]          r_size;

  logic [CW-1:0]       w_bnd_bytes;
  logic [CW-1:0]       w_to_bnd;
  logic [8:0]          w_sub;
  logic                w_beat;
  logic                w_unused_ok;

  // Beats left before the boundary; 1..2**(BOUNDARY_BIT-BEAT_SH) for a beat-aligned address.
  assign w_bnd_bytes = CW'(1 << BOUNDARY_BIT) - CW'(r_cur_addr[BOUNDARY_BIT-1:0]);
  assign w_to_bnd    = w_bnd_bytes >> BEAT_SH;
  // When the boundary is nearer than rem, to_bnd < rem <= 256 so it fits 9 bits.
  assign w_sub       = (CW'(r_rem) <= w_to_bnd) ? r_rem : w_to_bnd[8:0];

  assign w_beat      = (r_state == ST_DATA) && m.rvalid && s.rready;

  assign m.araddr    = r_cur_addr;
  assign m.arlen     = 8'(w_sub - 9'd1);
  assign m.arsize    = r_size;
  assign m.arburst   = 2'b01;
  assign m.arid      = r_id;
  assign s.rdata     = m.rdata;
  assign s.rresp     = m.rresp;
  assign s.rid       = r_id;
  assign w_unused_ok = ^{s.arburst, m.rid, m.rlast};

  always_comb begin
    w_state_nxt = r_state;
    s.arready   = 1'b0;
    m.arvalid   = 1'b0;
    m.rready    = 1'b0;
    s.rvalid    = 1'b0;
    s.rlast     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s.arready = 1'b1;
        if (s.arvalid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        m.arvalid = 1'b1;
        if (m.arready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s.rvalid = m.rvalid;
        m.rready = s.rready;
        // Only the final beat of the whole request is marked; sub-burst rlast is dropped.
        s.rlast  = m.rvalid && (r_rem == 9'd1);
        if (w_beat) begin
          if (r_rem == 9'd1)          w_state_nxt = ST_IDLE;
          else if (r_sub_cnt == 9'd1) w_state_nxt = ST_ISSUE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= '0;
      r_rem      <= '0;
      r_sub_cnt  <= '0;
      r_sub      <= '0;
      r_id       <= '0;
      r_size     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (s.arvalid) begin
            r_cur_addr <= s.araddr;
            r_rem      <= {1'b0, s.arlen} + 9'd1;
            r_id       <= s.arid;
            r_size     <= s.arsize;
          end
        end
        ST_ISSUE: begin
          if (m.arready) begin
            r_sub_cnt <= w_sub;
            r_sub     <= w_sub;
          end
        end
        ST_DATA: begin
          if (w_beat) begin
            r_sub_cnt <= r_sub_cnt - 9'd1;
            r_rem     <= r_rem - 9'd1;
            if (r_sub_cnt == 9'd1 && r_rem != 9'd1)
              r_cur_addr <= r_cur_addr + (ADDR_WTH'(r_sub) << BEAT_SH);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_RD_SPLIT_CHECK_EN
  logic r_chk_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_chk_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && s.arvalid &&
          (s.arsize != 3'(BEAT_SH) || s.arburst != 2'b01 || s.araddr[BEAT_SH-1:0] != '0)) begin
        r_chk_err <= 1'b1;
        $display("[ERROR] axi_rd_4k_splitter: illegal AR addr=%h size=%0d burst=%0d",
                 s.araddr, s.arsize, s.arburst);
      end
      if (w_beat && (m.rlast != (r_sub_cnt == 9'd1))) begin
        r_chk_err <= 1'b1;
        $display("[ERROR] axi_rd_4k_splitter: m_rlast=%0b with sub_cnt=%0d", m.rlast, r_sub_cnt);
      end
    end
  end

  assign chk_err_o = r_chk_err;
`else
  assign chk_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi_rd_4k_splitter.sv
// tb/tb_axi_rd_4k_splitter.sv - directed self-checking bench for axi_rd_4k_splitter
module tb_axi_rd_4k_splitter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_err;

  always #5 clk = ~clk;

  axi_rd_4k_splitter_if #(.ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IW)) s_if ();
  axi_rd_4k_splitter_if #(.ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IW)) m_if ();

  axi_rd_4k_splitter #(.ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IW), .BOUNDARY_BIT(12)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .s         (s_if),
    .m         (m_if),
    .chk_err_o (chk_err)
  );

  int errors = 0;
  int checks = 0;

  // Test controls (written only by the main sequence).
  int ar_stall = 0;
  bit rtoggle  = 1'b0;
  // Slave-model observations (written only by the slave process).
  int stab_err = 0;
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [31:0] bd_q[$];
  logic        bl_q[$];
  logic [3:0]  bid_q[$];
  int          clr_req = 0;

  // Memory slave model: beat data = byte address of the beat. Drives on negedge,
  // samples handshakes 1ns later (stable until the next posedge).
  initial begin : slave_model
    bit ar_hs, r_hs, up_hs, prev_wait, sl_busy;
    logic [31:0] cap_araddr, prev_addr, cap_rdata, sl_addr;
    logic [7:0]  cap_arlen, prev_len;
    logic        cap_rlast;
    logic [3:0]  cap_rid;
    int sl_left, waited, clr_seen;
    ar_hs = 0; r_hs = 0; up_hs = 0; prev_wait = 0; sl_busy = 0; sl_left = 0; waited = 0;
    sl_addr = '0; prev_addr = '0; prev_len = '0; clr_seen = 0;
    cap_araddr = '0; cap_arlen = '0; cap_rdata = '0; cap_rlast = 0; cap_rid = '0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = 2'b00;
    m_if.rid = '0; m_if.rlast = 0; s_if.rready = 0;
    forever begin
      @(negedge clk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        ar_addr_q.delete(); ar_len_q.delete(); bd_q.delete(); bl_q.delete(); bid_q.delete();
      end
      if (!rst_n) begin
        sl_busy = 0; ar_hs = 0; r_hs = 0; up_hs = 0; prev_wait = 0; waited = 0;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rlast = 0; s_if.rready = 0;
      end else begin
        if (r_hs) begin
          sl_addr += 32; sl_left--;
          if (sl_left == 0) sl_busy = 0;
        end
        if (ar_hs) begin
          ar_addr_q.push_back(cap_araddr); ar_len_q.push_back(cap_arlen);
          sl_busy = 1; sl_left = int'(cap_arlen) + 1; sl_addr = cap_araddr; waited = 0;
        end
        if (up_hs) begin
          bd_q.push_back(cap_rdata); bl_q.push_back(cap_rlast); bid_q.push_back(cap_rid);
        end
        m_if.arready = !sl_busy && (waited >= ar_stall);
        if (m_if.arvalid && !m_if.arready) waited++;
        m_if.rvalid = sl_busy;
        m_if.rdata  = {224'd0, sl_addr};
        m_if.rlast  = sl_busy && (sl_left == 1);
        s_if.rready = rtoggle ? !s_if.rready : 1'b1;
        #1;
        ar_hs = m_if.arvalid && m_if.arready;
        cap_araddr = m_if.araddr; cap_arlen = m_if.arlen;
        if (prev_wait && m_if.arvalid && (m_if.araddr !== prev_addr || m_if.arlen !== prev_len))
          stab_err++;
        prev_wait = m_if.arvalid && !m_if.arready;
        prev_addr = m_if.araddr; prev_len = m_if.arlen;
        r_hs  = m_if.rvalid && m_if.rready;
        up_hs = s_if.rvalid && s_if.rready;
        cap_rdata = s_if.rdata[31:0]; cap_rlast = s_if.rlast; cap_rid = s_if.rid;
      end
    end
  end

  function automatic logic [31:0] q_addr(input int i);
    return (i < ar_addr_q.size()) ? ar_addr_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [7:0] q_len(input int i);
    return (i < ar_len_q.size()) ? ar_len_q[i] : 8'hxx;
  endfunction

  // Number of upstream beats that differ from the expected contiguous burst.
  function automatic int beat_bad(input logic [31:0] base, input int n);
    int bad = 0;
    for (int i = 0; i < bd_q.size(); i++)
      if (bd_q[i] !== base + 32'(32 * i) || bl_q[i] !== (i == n - 1) || bid_q[i] !== 4'h5) bad++;
    return bad;
  endfunction

  task automatic clear_q;
    clr_req++;
    @(negedge clk); #2;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         output bit ok);
    int n = 0;
    @(negedge clk);
    s_if.araddr = addr; s_if.arlen = len; s_if.arsize = size;
    s_if.arburst = 2'b01; s_if.arid = 4'h5; s_if.arvalid = 1'b1;
    #1;
    while (!s_if.arready && n < 50) begin @(negedge clk); #1; n++; end
    ok = s_if.arready;
    @(posedge clk); #1;
    s_if.arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n, output bit ok);
    int c = 0;
    while (bd_q.size() < n && c < 2000) begin @(negedge clk); #2; c++; end
    ok = (bd_q.size() >= n);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          output bit ok);
    bit a, b;
    send_ar(addr, len, size, a);
    wait_beats(int'(len) + 1, b);
    repeat (4) @(negedge clk);
    #2;
    ok = a && b;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s_if.arvalid = 0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = 3'd5;
    s_if.arburst = 2'b01; s_if.arid = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s_if.arready !== 1'b1) begin errors++; $display("FAIL rst_s_arready: got %b want 1", s_if.arready); end
    checks++; if (m_if.arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid: got %b want 0", m_if.arvalid); end
    checks++; if (m_if.rready !== 1'b0) begin errors++; $display("FAIL rst_m_rready: got %b want 0", m_if.rready); end
    checks++; if (s_if.rvalid !== 1'b0) begin errors++; $display("FAIL rst_s_rvalid: got %b want 0", s_if.rvalid); end
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL rst_chk_err: got %b want 0", chk_err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    clear_q();
    run_read(32'h8000_0000, 8'd7, 3'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_timeout: got %0d beats want 8", bd_q.size()); end
    checks++; if (ar_addr_q.size() != 1) begin errors++; $display("FAIL t1_ar_count: got %0d want 1", ar_addr_q.size()); end
    checks++; if (q_addr(0) !== 32'h8000_0000 || q_len(0) !== 8'd7) begin errors++; $display("FAIL t1_ar0: got %h/%0d want 80000000/7", q_addr(0), q_len(0)); end
    checks++; if (bd_q.size() != 8 || beat_bad(32'h8000_0000, 8) != 0) begin errors++; $display("FAIL t1_beats: got %0d beats %0d bad want 8 beats 0 bad", bd_q.size(), beat_bad(32'h8000_0000, 8)); end
    checks++; if (s_if.arready !== 1'b1 || m_if.rready !== 1'b0) begin errors++; $display("FAIL t1_idle: got arready=%b rready=%b want 1/0", s_if.arready, m_if.rready); end
  endtask

  task automatic test_cross_small;
    bit ok;
    clear_q();
    run_read(32'h8000_0FC0, 8'd3, 3'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_timeout: got %0d beats want 4", bd_q.size()); end
    checks++; if (ar_addr_q.size() != 2) begin errors++; $display("FAIL t2_ar_count: got %0d want 2", ar_addr_q.size()); end
    checks++; if (q_addr(0) !== 32'h8000_0FC0 || q_len(0) !== 8'd1) begin errors++; $display("FAIL t2_ar0: got %h/%0d want 80000fc0/1", q_addr(0), q_len(0)); end
    checks++; if (q_addr(1) !== 32'h8000_1000 || q_len(1) !== 8'd1) begin errors++; $display("FAIL t2_ar1: got %h/%0d want 80001000/1", q_addr(1), q_len(1)); end
    checks++; if (bd_q.size() != 4 || beat_bad(32'h8000_0FC0, 4) != 0) begin errors++; $display("FAIL t2_beats: got %0d beats %0d bad want 4 beats 0 bad", bd_q.size(), beat_bad(32'h8000_0FC0, 4)); end
  endtask

  task automatic test_cross_long;
    bit ok;
    clear_q();
    run_read(32'h8000_0000, 8'd255, 3'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_timeout: got %0d beats want 256", bd_q.size()); end
    checks++; if (ar_addr_q.size() != 2) begin errors++; $display("FAIL t3_ar_count: got %0d want 2", ar_addr_q.size()); end
    checks++; if (q_addr(0) !== 32'h8000_0000 || q_len(0) !== 8'd127) begin errors++; $display("FAIL t3_ar0: got %h/%0d want 80000000/127", q_addr(0), q_len(0)); end
    checks++; if (q_addr(1) !== 32'h8000_1000 || q_len(1) !== 8'd127) begin errors++; $display("FAIL t3_ar1: got %h/%0d want 80001000/127", q_addr(1), q_len(1)); end
    checks++; if (bd_q.size() != 256 || beat_bad(32'h8000_0000, 256) != 0) begin errors++; $display("FAIL t3_beats: got %0d beats %0d bad want 256 beats 0 bad", bd_q.size(), beat_bad(32'h8000_0000, 256)); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int stab0;
    clear_q();
    stab0 = stab_err;
    ar_stall = 5;
    rtoggle = 1'b1;
    run_read(32'h8000_0FC0, 8'd3, 3'd5, ok);
    ar_stall = 0;
    rtoggle = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL t4_timeout: got %0d beats want 4", bd_q.size()); end
    checks++; if (q_addr(0) !== 32'h8000_0FC0 || q_len(0) !== 8'd1 || q_addr(1) !== 32'h8000_1000 || q_len(1) !== 8'd1 || ar_addr_q.size() != 2) begin errors++; $display("FAIL t4_ar: got %0d ars first %h/%0d want 2 ars 80000fc0/1 80001000/1", ar_addr_q.size(), q_addr(0), q_len(0)); end
    checks++; if (bd_q.size() != 4 || beat_bad(32'h8000_0FC0, 4) != 0) begin errors++; $display("FAIL t4_beats: got %0d beats %0d bad want 4 beats 0 bad", bd_q.size(), beat_bad(32'h8000_0FC0, 4)); end
    checks++; if (stab_err != stab0) begin errors++; $display("FAIL t4_ar_stable: got %0d changes want 0", stab_err - stab0); end
  endtask

  task automatic test_reset_mid;
    bit ok, okw;
    clear_q();
    send_ar(32'h8000_0000, 8'd255, 3'd5, ok);
    wait_beats(1, okw);
    checks++; if (!(ok && okw)) begin errors++; $display("FAIL t5_start: got %0d beats want 1", bd_q.size()); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (s_if.arready !== 1'b1 || m_if.arvalid !== 1'b0 || m_if.rready !== 1'b0 || s_if.rvalid !== 1'b0 || chk_err !== 1'b0) begin errors++; $display("FAIL t5_rst_outputs: got arready=%b arvalid=%b rready=%b rvalid=%b err=%b want 1 0 0 0 0", s_if.arready, m_if.arvalid, m_if.rready, s_if.rvalid, chk_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    run_read(32'h8000_0040, 8'd0, 3'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_timeout: got %0d beats want 1", bd_q.size()); end
    checks++; if (ar_addr_q.size() != 1 || q_addr(0) !== 32'h8000_0040 || q_len(0) !== 8'd0) begin errors++; $display("FAIL t5_ar: got %0d ars %h/%0d want 1 ar 80000040/0", ar_addr_q.size(), q_addr(0), q_len(0)); end
    checks++; if (bd_q.size() != 1 || beat_bad(32'h8000_0040, 1) != 0) begin errors++; $display("FAIL t5_beats: got %0d beats %0d bad want 1 beat 0 bad", bd_q.size(), beat_bad(32'h8000_0040, 1)); end
  endtask

  task automatic test_check;
    bit ok;
    logic exp_err;
`ifdef AXI_RD_SPLIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    clear_q();
    run_read(32'h8000_0000, 8'd0, 3'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_timeout: got %0d beats want 1", bd_q.size()); end
    checks++; if (chk_err !== exp_err) begin errors++; $display("FAIL t6_chk_set: got %b want %b", chk_err, exp_err); end
    clear_q();
    run_read(32'h8000_0100, 8'd1, 3'd5, ok);
    checks++; if (!ok || chk_err !== exp_err) begin errors++; $display("FAIL t6_chk_sticky: got %b ok=%0b want %b", chk_err, ok, exp_err); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL t6_chk_clear: got %b want 0", chk_err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_cross_small();
    test_cross_long();
    test_backpressure();
    test_reset_mid();
    test_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
